// File: rtl/baud_gen_frac_pkg.sv
// Shared helpers for the UART baud generator and the RX/TX blocks that reuse
// its divisor arithmetic.
package baud_gen_frac_pkg;

    // Bits needed to count 0..value-1 (at least 1).
    function automatic int clog2(input longint value);
        int     w;
        longint v;
        w = 0;
        v = value - 1;
        while (v > 0) begin
            w++;
            v = v >>> 1;
        end
        return (w < 1) ? 1 : w;
    endfunction

    // Fixed-point divisor (FRAC_NBITS fraction bits) rounded to nearest.
    function automatic longint calc_div_reset(input real clk_freq, input real baud_rate,
                                              input int oversample, input int frac_nbits);
        real exact;
        exact = clk_freq * (2.0 ** frac_nbits) / (real'(oversample) * baud_rate);
        return longint'($rtoi(exact + 0.5));
    endfunction

endpackage

// File: rtl/baud_frac_acc.sv
// Fractional phase accumulator: the carry stretches the current period by one cycle.
module baud_frac_acc #(
    parameter int FRAC_NBITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  adv,
    input  logic                  clr,
    input  logic [FRAC_NBITS-1:0] frac,
    output logic                  carry
);

    logic [FRAC_NBITS-1:0] acc;
    logic [FRAC_NBITS:0]   sum;

    assign sum   = {1'b0, acc} + {1'b0, frac};
    assign carry = sum[FRAC_NBITS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            acc <= '0;
        else if (clr)
            acc <= '0;
        else if (adv)
            acc <= sum[FRAC_NBITS-1:0];
    end

endmodule

// File: rtl/baud_gen_frac.sv
// Fractional baud-rate generator: oversample, mid-bit and bit-boundary ticks
// with glitch-free divisor updates at period boundaries and RX phase sync.
module baud_gen_frac
    import baud_gen_frac_pkg::*;
#(
    parameter real CLK_FREQ   = 100E6,
    parameter int  BAUD_RATE  = 9600,
    parameter int  OVERSAMPLE = 16,
    parameter int  INT_NBITS  = 16,
    parameter int  FRAC_NBITS = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_enable,
    input  logic [INT_NBITS-1:0]  i_div_int,
    input  logic [FRAC_NBITS-1:0] i_div_frac,
    input  logic                  i_div_load,
    input  logic                  i_sync,
    output logic                  o_tick,
    output logic                  o_mid_tick,
    output logic                  o_bit_tick,
    output logic                  o_div_ack,
    output logic                  o_cfg_err
);

    localparam longint DIV_RESET = calc_div_reset(CLK_FREQ, real'(BAUD_RATE), OVERSAMPLE, FRAC_NBITS);
    localparam logic [INT_NBITS-1:0]  RST_INT  = INT_NBITS'(DIV_RESET >>> FRAC_NBITS);
    localparam logic [FRAC_NBITS-1:0] RST_FRAC = FRAC_NBITS'(DIV_RESET);
    localparam logic [INT_NBITS-1:0]  ONE      = INT_NBITS'(1);
    localparam int                    OS_W     = clog2(OVERSAMPLE);
    localparam logic [OS_W-1:0]       OS_LAST  = OS_W'(OVERSAMPLE - 1);
    localparam logic [OS_W-1:0]       OS_PRE_MID = OS_W'(OVERSAMPLE / 2 - 1);

    logic [INT_NBITS-1:0]  cnt;
    logic [INT_NBITS-1:0]  act_int, pend_int, nxt_int;
    logic [FRAC_NBITS-1:0] act_frac, pend_frac, nxt_frac;
    logic                  pend_vld;
    logic [OS_W-1:0]       os_cnt;
    logic                  load_ok, load_bad, tick_ev, apply_now, apply_pend, carry;

    assign load_ok    = i_div_load && (i_div_int != '0);
    assign load_bad   = i_div_load && (i_div_int == '0);
    assign tick_ev    = i_enable && (cnt == '0) && !i_sync;
    assign apply_now  = i_sync && load_ok;
    // A pending divisor waits for the period boundary, or goes straight in while frozen.
    assign apply_pend = pend_vld && !apply_now && (tick_ev || !i_enable);

    always_comb begin
        nxt_int  = act_int;
        nxt_frac = act_frac;
        if (apply_now) begin
            nxt_int  = i_div_int;
            nxt_frac = i_div_frac;
        end else if (apply_pend) begin
            nxt_int  = pend_int;
            nxt_frac = pend_frac;
        end
    end

    baud_frac_acc #(
        .FRAC_NBITS (FRAC_NBITS)
    ) u_acc (
        .clk   (i_clk),
        .rst   (i_rst),
        .adv   (tick_ev),
        .clr   (i_sync),
        .frac  (nxt_frac),
        .carry (carry)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt        <= RST_INT - ONE;
            act_int    <= RST_INT;
            act_frac   <= RST_FRAC;
            pend_int   <= '0;
            pend_frac  <= '0;
            pend_vld   <= 1'b0;
            os_cnt     <= '0;
            o_tick     <= 1'b0;
            o_mid_tick <= 1'b0;
            o_bit_tick <= 1'b0;
            o_div_ack  <= 1'b0;
            o_cfg_err  <= 1'b0;
        end else begin
            act_int  <= nxt_int;
            act_frac <= nxt_frac;

            // Sync has no accumulator carry: the accumulator restarts from zero.
            if (i_sync)
                cnt <= nxt_int - ONE;
            else if (tick_ev)
                cnt <= nxt_int - ONE + INT_NBITS'(carry);
            else if (i_enable)
                cnt <= cnt - ONE;

            if (i_sync)
                os_cnt <= '0;
            else if (tick_ev)
                os_cnt <= (os_cnt == OS_LAST) ? '0 : os_cnt + OS_W'(1);

            if (load_ok && !i_sync) begin
                pend_int  <= i_div_int;
                pend_frac <= i_div_frac;
                pend_vld  <= 1'b1;
            end else if (apply_now || apply_pend) begin
                pend_vld  <= 1'b0;
            end

            o_tick     <= tick_ev;
            o_mid_tick <= tick_ev && (os_cnt == OS_PRE_MID);
            o_bit_tick <= tick_ev && (os_cnt == OS_LAST);
            o_div_ack  <= apply_now || apply_pend;
            o_cfg_err  <= load_bad;
        end
    end

endmodule

// File: tb/tb_baud_gen_frac.sv
// Directed + randomized bench for baud_gen_frac (default parameters) against a
// cycle-counting reference model built from the divisor/tick rules.
module tb_baud_gen_frac;

    localparam int OS       = 16;
    localparam int FONE     = 16;   // 2**FRAC_NBITS
    localparam int RST_INT  = 651;  // round(100e6*16/(16*9600)) = 10417 = 651 + 1/16
    localparam int RST_FRAC = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0, sync = 1'b0, div_load = 1'b0;
    logic [15:0] div_int = '0;
    logic [3:0]  div_frac = '0;
    logic        tick, mid_tick, bit_tick, div_ack, cfg_err;

    int n_pass = 0, n_tot = 0;

    // Reference model: divisor in force, pending divisor, fractional phase,
    // ticks since sync, enabled cycles since last tick, expected period.
    int m_int, m_frac, m_acc, m_os, p_int, p_frac, since, gap, m_ticks;
    bit m_pend;

    baud_gen_frac dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_enable   (en),
        .i_div_int  (div_int),
        .i_div_frac (div_frac),
        .i_div_load (div_load),
        .i_sync     (sync),
        .o_tick     (tick),
        .o_mid_tick (mid_tick),
        .o_bit_tick (bit_tick),
        .o_div_ack  (div_ack),
        .o_cfg_err  (cfg_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0d expected %0d (cycle model tick %0d)", tag, obs, exp, m_ticks);
    endtask

    task automatic model_reset();
        m_int = RST_INT; m_frac = RST_FRAC; m_acc = 0; m_os = 0;
        m_pend = 0; since = 0; gap = RST_INT;
    endtask

    // One clock: sample inputs at the edge, check outputs at the following negedge.
    task automatic cycle();
        logic en_s, sync_s, ld_s;
        int   di_s, df_s;
        bit   e_tick, e_mid, e_bit, e_ack, e_err;
        @(posedge clk);
        en_s = en; sync_s = sync; ld_s = div_load; di_s = div_int; df_s = div_frac;
        @(negedge clk);
        e_tick = 0; e_mid = 0; e_bit = 0; e_ack = 0;
        e_err  = ld_s && di_s == 0;
        if (sync_s) begin
            if (ld_s && di_s != 0) begin
                m_int = di_s; m_frac = df_s; m_pend = 0; e_ack = 1;
            end else if (m_pend && !en_s) begin
                m_int = p_int; m_frac = p_frac; m_pend = 0; e_ack = 1;
            end
            m_acc = 0; m_os = 0; since = 0; gap = m_int;
        end else if (en_s) begin
            since++;
            if (since == gap) begin
                e_tick = 1;
                if (m_pend) begin
                    m_int = p_int; m_frac = p_frac; m_pend = 0; e_ack = 1;
                end
                gap   = m_int + ((m_acc + m_frac >= FONE) ? 1 : 0);
                m_acc = (m_acc + m_frac) % FONE;
                m_os  = (m_os + 1) % OS;
                e_mid = (m_os == OS / 2);
                e_bit = (m_os == 0);
                since = 0;
                m_ticks++;
            end
        end else if (m_pend) begin
            m_int = p_int; m_frac = p_frac; m_pend = 0; e_ack = 1;
        end
        if (!sync_s && ld_s && di_s != 0) begin
            p_int = di_s; p_frac = df_s; m_pend = 1;
        end
        chk("tick", tick, e_tick);
        chk("mid_tick", mid_tick, e_mid);
        chk("bit_tick", bit_tick, e_bit);
        chk("div_ack", div_ack, e_ack);
        chk("cfg_err", cfg_err, e_err);
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic wait_ticks(input int n);
        int target, lim;
        target = m_ticks + n;
        lim    = n * 700 + 1000;
        while (m_ticks < target && lim > 0) begin
            cycle();
            lim--;
        end
        if (m_ticks < target) chk("tick_timeout", m_ticks, target);
    endtask

    task automatic pulse_load(input int di, input int df);
        div_load = 1'b1; div_int = 16'(di); div_frac = 4'(df);
        cycle();
        div_load = 1'b0;
    endtask

    // Async reset asserted between edges; outputs must clear without a clock.
    task automatic do_reset();
        #2 rst = 1'b1;
        #1;
        chk("rst_async_tick", tick, 0);
        chk("rst_async_mid", mid_tick, 0);
        chk("rst_async_bit", bit_tick, 0);
        chk("rst_async_ack", div_ack, 0);
        chk("rst_async_err", cfg_err, 0);
        @(negedge clk);
        @(negedge clk);
        model_reset();
        rst = 1'b0;
    endtask

    initial begin
        int r;
        m_ticks = 0;
        model_reset();
        en = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_tick", tick, 0);
        chk("rst_mid", mid_tick, 0);
        chk("rst_bit", bit_tick, 0);
        chk("rst_ack", div_ack, 0);
        chk("rst_err", cfg_err, 0);
        rst = 1'b0;

        // Default divisor: first tick after 651 cycles, a 652 gap every 16 ticks.
        wait_ticks(18);

        // Mid-period load of 4 + 8/16: current period finishes, then 4,5,4,5.
        run_cycles($urandom_range(10, 400));
        pulse_load(4, 8);
        wait_ticks(12);

        // Rejected load: error pulse only, spacing unchanged.
        run_cycles($urandom_range(0, 3));
        pulse_load(0, $urandom_range(0, 15));
        wait_ticks(6);

        // Sync landing exactly on a tick cycle, then a sync at a random point.
        for (int i = 0; i < 20 && !(since == gap - 1); i++) cycle();
        sync = 1'b1;
        cycle();
        sync = 1'b0;
        wait_ticks(9);
        run_cycles($urandom_range(0, 3));
        sync = 1'b1;
        cycle();
        sync = 1'b0;
        wait_ticks(9);

        // Randomized loads, bad loads, syncs, sync+load and enable toggling.
        for (int i = 0; i < 1500; i++) begin
            r = int'($urandom_range(0, 99));
            div_load = 1'b0;
            sync     = 1'b0;
            if (r < 4) begin
                div_load = 1'b1; div_int = 16'($urandom_range(1, 9)); div_frac = 4'($urandom_range(0, 15));
            end else if (r < 5) begin
                div_load = 1'b1; div_int = '0; div_frac = 4'($urandom_range(0, 15));
            end else if (r < 7) begin
                sync = 1'b1;
            end else if (r < 8) begin
                sync = 1'b1; div_load = 1'b1;
                div_int = 16'($urandom_range(1, 9)); div_frac = 4'($urandom_range(0, 15));
            end else if (r < 11) begin
                en = ~en;
            end
            cycle();
        end
        div_load = 1'b0;
        sync     = 1'b0;
        en       = 1'b1;
        wait_ticks(4);

        // Divisor 1/0: tick every cycle, mid and bit every 16, offset by 8.
        pulse_load(1, 0);
        wait_ticks(12);
        run_cycles(40);

        // Reset while o_tick is high continuously.
        do_reset();

        // Enable low for 100 cycles mid-period, with a load applied while frozen.
        run_cycles(200);
        en = 1'b0;
        run_cycles(50);
        pulse_load(5, 3);
        run_cycles(49);
        en = 1'b1;
        wait_ticks(4);

        // Reset with a divisor pending: it must be discarded, no ack afterwards.
        do_reset();
        run_cycles(100);
        pulse_load(3, 0);
        run_cycles(50);
        do_reset();
        wait_ticks(2);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/baud_gen_frac.md
BAUD_GEN_FRAC -- requirements
Module: baud_gen_frac

Interface
REQ-001 The block SHALL have parameter CLK_FREQ, default 100E6, system clock frequency in Hz.
REQ-002 The block SHALL have parameter BAUD_RATE, default 9600, baud rate used to compute the reset divisor.
REQ-003 The block SHALL have parameter OVERSAMPLE, default 16, oversample ticks per bit; it SHALL be an even value of at least 2.
REQ-004 The block SHALL have parameter INT_NBITS, default 16, width of the integer divisor.
REQ-005 The block SHALL have parameter FRAC_NBITS, default 4, width of the fractional divisor.
REQ-006 The block SHALL have port i_clk, input, 1 bit: the single clock, rising edge.
REQ-007 The block SHALL have port i_rst, input, 1 bit: asynchronous, active-high reset.
REQ-008 The block SHALL have port i_enable, input, 1 bit: high lets the divider run; low freezes it.
REQ-009 The block SHALL have port i_div_int, input, INT_NBITS bits: new integer divisor.
REQ-010 The block SHALL have port i_div_frac, input, FRAC_NBITS bits: new fractional divisor, in units of 1/2^FRAC_NBITS.
REQ-011 The block SHALL have port i_div_load, input, 1 bit: single-cycle request to capture i_div_int and i_div_frac.
REQ-012 The block SHALL have port i_sync, input, 1 bit: single-cycle phase restart, used for RX start-bit alignment.
REQ-013 The block SHALL have port o_tick, output, 1 bit: oversample tick, high for one cycle.
REQ-014 The block SHALL have port o_mid_tick, output, 1 bit: tick at the mid-bit point, for RX sampling.
REQ-015 The block SHALL have port o_bit_tick, output, 1 bit: tick at the bit boundary.
REQ-016 The block SHALL have port o_div_ack, output, 1 bit: one-cycle pulse when a pending divisor becomes active.
REQ-017 The block SHALL have port o_cfg_err, output, 1 bit: one-cycle pulse when a load is rejected.

Function
REQ-018 The active period SHALL be L = div_int + c cycles, where c is the carry out of the FRAC_NBITS-bit accumulator; at each tick the accumulator SHALL be updated as acc <= acc + div_frac.
REQ-019 With i_enable held high, o_tick SHALL pulse once every L cycles; with div_frac=0, ticks SHALL be exactly div_int cycles apart.
REQ-020 When div_int=1 and div_frac=0, o_tick SHALL be high continuously.
REQ-021 The oversample counter SHALL be ceil(log2(OVERSAMPLE)) bits wide and SHALL increment on each tick, wrapping from OVERSAMPLE-1 to 0.
REQ-022 o_bit_tick SHALL be coincident with the o_tick that wraps the oversample counter to 0.
REQ-023 o_mid_tick SHALL be coincident with the o_tick that moves the oversample counter to OVERSAMPLE/2.
REQ-024 While i_enable is low, the period counter, accumulator and oversample counter SHALL hold their values, and all tick outputs SHALL be 0.
REQ-025 On i_enable rising, counting SHALL resume from the held counter values.
REQ-026 i_div_load SHALL capture the inputs into a pending register; a later load before application SHALL overwrite the pending value (latest wins).
REQ-027 A pending divisor SHALL become active at the end of the current period, i.e. in the cycle a tick is generated; while i_enable is low it SHALL become active on the next cycle.
REQ-028 o_div_ack SHALL pulse in the cycle a pending divisor becomes active.
REQ-029 A load with i_div_int=0 SHALL be rejected: o_cfg_err pulses on the next cycle, and both the pending and active divisors are unchanged.
REQ-030 i_sync SHALL reload the period counter with the full active period, clear the accumulator and oversample counter, and suppress any tick in that cycle; sync SHALL win over a simultaneous tick.
REQ-031 If i_sync and i_div_load are high in the same cycle, the newly loaded valid divisor SHALL become active immediately and o_div_ack SHALL pulse.
REQ-032 After a sync, the first o_tick SHALL occur L cycles later, and the first o_mid_tick SHALL occur after OVERSAMPLE/2 ticks.
REQ-033 All outputs SHALL be registered.

Reset
REQ-034 i_rst SHALL act asynchronously, and all state SHALL be clear while it is high.
REQ-035 On reset, the active divisor SHALL take DIV_RESET = round(CLK_FREQ*2^FRAC_NBITS/(OVERSAMPLE*BAUD_RATE)), split into its integer and fractional parts.
REQ-036 On reset, the period counter SHALL be loaded with int(DIV_RESET)-1, the accumulator and oversample counter set to 0, and no divisor left pending.
REQ-037 All outputs SHALL be 0 during reset.
REQ-038 The first tick SHALL occur int(DIV_RESET) enabled cycles after reset is released.
REQ-039 Reset asserted mid-period or with a divisor pending SHALL discard the pending divisor; no o_div_ack SHALL follow.

Structure
REQ-040 The clog2 function and the DIV_RESET computation SHALL live in the shared header, alongside the existing clog2 header, for reuse by the UART RX/TX blocks.
REQ-041 A sub-module baud_frac_acc SHALL hold the accumulator and produce the carry bit; all other logic SHALL remain in baud_gen_frac.

Verification
REQ-042 Reset release, enable high, defaults (100 MHz, 9600, OVERSAMPLE 16, FRAC_NBITS 4) -> DIV_RESET=10417 (651 + 1/16); fifteen ticks 651 cycles apart and one 652 per 16 ticks; o_bit_tick every 16 ticks.
REQ-043 Load div_int=4, frac=8 mid-period -> current period completes unchanged, o_div_ack pulses with that tick, tick spacing then alternates 4,5,4,5.
REQ-044 Load div_int=0 -> o_cfg_err pulses once; tick spacing is unchanged; no o_div_ack.
REQ-045 div_int=1, frac=0 -> o_tick high every cycle, o_mid_tick every 16 cycles, o_bit_tick every 16 cycles offset by 8.
REQ-046 i_sync in the same cycle as an expected tick -> no tick that cycle; the next tick follows L cycles later; o_mid_tick after 8 ticks.
REQ-047 Enable low for 100 cycles mid-period, then high -> no ticks while low; the remaining count resumes; i_rst pulse mid-period with a divisor pending -> outputs 0 immediately, pending divisor discarded.
